cntx_table: RTL and testbench

Parametrised speculative-context tracker between fetch/decode and the execution units of the core. It tracks up to N_CNTX contexts, each with a next-PC, a fetch-pending flag and a descendant mask. It allocates two child contexts per decoded branch from a true free list, so allocation stalls when contexts run out instead of silently wrapping. When a branch resolves, it frees the discarded subtree and reports the kill set as a flush mask.

---
 rtl/cntx_table.sv | 240 ++++++++++++++++++++++++
 tb/tb_cntx_table.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cntx_table.sv
// cntx_table: speculative-context tracker with a true free list and subtree kill on resolve.
// Defining CNTX_PERF_CNT_EN adds saturating perf_flush/perf_stall/perf_fetch counters.
module cntx_table #(
    parameter int N_CNTX   = 8,
    parameter int PARA     = 2,
    parameter int LEN_WORD = 32,
    localparam int ID_W    = $clog2(N_CNTX)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init,
    input  logic [LEN_WORD-1:0]      init_pc,
    output logic [PARA-1:0]          fetch_valid,
    input  logic [PARA-1:0]          fetch_ready,
    output logic [PARA*LEN_WORD-1:0] fetch_pc,
    output logic [PARA*ID_W-1:0]     fetch_cntx,
    input  logic [PARA-1:0]          dec_next_pc_valid,
    input  logic [PARA*LEN_WORD-1:0] dec_next_pc,
    input  logic [PARA-1:0]          dec_branch,
    input  logic [PARA*LEN_WORD-1:0] dec_pc_f,
    output logic [PARA*ID_W-1:0]     alloc_t_id,
    output logic [PARA*ID_W-1:0]     alloc_f_id,
    input  logic                     jmp_valid,
    input  logic [ID_W-1:0]          jmp_cntx,
    input  logic [LEN_WORD-1:0]      jmp_pc,
    input  logic                     res_valid,
    input  logic [ID_W-1:0]          res_keep_id,
    input  logic [ID_W-1:0]          res_kill_id,
    output logic                     flush_valid,
    output logic [N_CNTX-1:0]        flush_mask,
    output logic [ID_W:0]            free_cnt
`ifdef CNTX_PERF_CNT_EN
    ,
    output logic [31:0]              perf_flush,
    output logic [31:0]              perf_stall,
    output logic [31:0]              perf_fetch
`endif
);

    localparam logic [ID_W:0] N_ID = (ID_W+1)'(N_CNTX);

    logic [N_CNTX-1:0]   valid_q, valid_d;
    logic [N_CNTX-1:0]   pend_q, pend_d;
    logic [LEN_WORD-1:0] pc_q [N_CNTX];
    logic [LEN_WORD-1:0] pc_d [N_CNTX];
    logic [N_CNTX-1:0]   desc_q [N_CNTX];
    logic [N_CNTX-1:0]   desc_d [N_CNTX];
    logic [ID_W-1:0]     hot_q, hot_d;
    logic                flush_valid_q;
    logic [N_CNTX-1:0]   flush_mask_q;
    logic [ID_W:0]       free_cnt_q, free_cnt_d;

    logic [N_CNTX-1:0]   kill;
    logic [N_CNTX-1:0]   free_m;
    logic [ID_W-1:0]     t_id, f_id;
    logic                got_t, got_f;
    logic                chain_ok;
    logic                slot_v;
`ifdef CNTX_PERF_CNT_EN
    logic [31:0]         n_acc;
`endif

    always_comb begin
        valid_d     = valid_q;
        pend_d      = pend_q;
        pc_d        = pc_q;
        desc_d      = desc_q;
        hot_d       = hot_q;
        kill        = '0;
        free_m      = ~valid_q;
        t_id        = '0;
        f_id        = '0;
        got_t       = 1'b0;
        got_f       = 1'b0;
        chain_ok    = 1'b1;
        slot_v      = 1'b0;
        fetch_valid = '0;
        fetch_pc    = '0;
        fetch_cntx  = '0;
        alloc_t_id  = '0;
        alloc_f_id  = '0;
        free_cnt_d  = '0;
`ifdef CNTX_PERF_CNT_EN
        n_acc       = '0;
`endif

        if (res_valid) begin
            if ({1'b0, res_kill_id} < N_ID)
                kill = desc_q[res_kill_id];
            valid_d = valid_d & ~kill;
            pend_d  = pend_d & ~kill;
            for (int unsigned i = 0; i < N_CNTX; i++)
                desc_d[i] = desc_d[i] & ~kill;
            if (kill[hot_d])
                hot_d = res_keep_id;
        end

        // valid_d already excludes the kill set, so a same-cycle jump into it is dropped
        if (jmp_valid && ({1'b0, jmp_cntx} < N_ID) && valid_d[jmp_cntx]) begin
            pc_d[jmp_cntx]   = jmp_pc;
            pend_d[jmp_cntx] = 1'b1;
        end

        for (int unsigned d = 0; d < PARA; d++) begin
            // free_m starts from pre-resolve state: freed contexts wait a cycle
            got_t = 1'b0;
            got_f = 1'b0;
            t_id  = '0;
            f_id  = '0;
            for (int unsigned i = 0; i < N_CNTX; i++) begin
                if (free_m[i] && !got_t) begin
                    t_id  = ID_W'(i);
                    got_t = 1'b1;
                end else if (free_m[i] && !got_f) begin
                    f_id  = ID_W'(i);
                    got_f = 1'b1;
                end
            end

            slot_v = chain_ok && pend_d[hot_d] && got_f && !init;
            fetch_valid[d]                   = slot_v;
            fetch_pc[d*LEN_WORD +: LEN_WORD] = pc_d[hot_d];
            fetch_cntx[d*ID_W +: ID_W]       = hot_d;
            alloc_t_id[d*ID_W +: ID_W]       = slot_v ? t_id : '0;
            alloc_f_id[d*ID_W +: ID_W]       = slot_v ? f_id : '0;

            if (slot_v && fetch_ready[d]) begin
`ifdef CNTX_PERF_CNT_EN
                n_acc = n_acc + 32'd1;
`endif
                if (dec_branch[d]) begin
                    for (int unsigned i = 0; i < N_CNTX; i++) begin
                        if (desc_d[i][hot_d]) begin
                            desc_d[i][t_id] = 1'b1;
                            desc_d[i][f_id] = 1'b1;
                        end
                    end
                    desc_d[t_id]       = '0;
                    desc_d[t_id][t_id] = 1'b1;
                    desc_d[f_id]       = '0;
                    desc_d[f_id][f_id] = 1'b1;
                    valid_d[t_id]      = 1'b1;
                    valid_d[f_id]      = 1'b1;
                    pend_d[t_id]       = 1'b1;
                    pend_d[f_id]       = 1'b1;
                    pc_d[t_id]         = dec_next_pc[d*LEN_WORD +: LEN_WORD];
                    pc_d[f_id]         = dec_pc_f[d*LEN_WORD +: LEN_WORD];
                    free_m[t_id]       = 1'b0;
                    free_m[f_id]       = 1'b0;
                    pend_d[hot_d]      = 1'b0;
                    hot_d              = t_id;
                end else begin
                    pend_d[hot_d] = dec_next_pc_valid[d];
                    if (dec_next_pc_valid[d])
                        pc_d[hot_d] = dec_next_pc[d*LEN_WORD +: LEN_WORD];
                end
            end else begin
                chain_ok = 1'b0;
            end
        end

        if (init) begin
            valid_d = '0;
            pend_d  = '0;
            for (int unsigned i = 0; i < N_CNTX; i++) begin
                pc_d[i]   = '0;
                desc_d[i] = '0;
            end
            valid_d[0]   = 1'b1;
            pend_d[0]    = 1'b1;
            pc_d[0]      = init_pc;
            desc_d[0][0] = 1'b1;
            hot_d        = '0;
        end

        for (int unsigned i = 0; i < N_CNTX; i++)
            if (!valid_d[i])
                free_cnt_d = free_cnt_d + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            pend_q        <= '0;
            for (int unsigned i = 0; i < N_CNTX; i++) begin
                pc_q[i]   <= '0;
                desc_q[i] <= '0;
            end
            hot_q         <= '0;
            flush_valid_q <= 1'b0;
            flush_mask_q  <= '0;
            free_cnt_q    <= N_ID;
        end else begin
            valid_q       <= valid_d;
            pend_q        <= pend_d;
            pc_q          <= pc_d;
            desc_q        <= desc_d;
            hot_q         <= hot_d;
            flush_valid_q <= res_valid && !init;
            flush_mask_q  <= init ? '0 : kill;
            free_cnt_q    <= free_cnt_d;
        end
    end

    assign flush_valid = flush_valid_q;
    assign flush_mask  = flush_mask_q;
    assign free_cnt    = free_cnt_q;

`ifdef CNTX_PERF_CNT_EN
    logic [31:0] perf_flush_q, perf_stall_q, perf_fetch_q;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_flush_q <= '0;
            perf_stall_q <= '0;
            perf_fetch_q <= '0;
        end else if (init) begin
            perf_flush_q <= '0;
            perf_stall_q <= '0;
            perf_fetch_q <= '0;
        end else begin
            perf_flush_q <= sat_add(perf_flush_q, {31'b0, res_valid && (|kill)});
            perf_stall_q <= sat_add(perf_stall_q,
                                    {31'b0, pend_q[hot_q] && (free_cnt_q < (ID_W+1)'(2))});
            perf_fetch_q <= sat_add(perf_fetch_q, n_acc);
        end
    end

    assign perf_flush = perf_flush_q;
    assign perf_stall = perf_stall_q;
    assign perf_fetch = perf_fetch_q;
`endif

endmodule

// File: tb/tb_cntx_table.sv
// Scoreboard bench for cntx_table: a context-tree reference model (parent links) predicts
// fetch/alloc, flush and free_cnt; a monitor pops and compares whenever the DUT presents them.
module tb_cntx_table;

    localparam int N  = 8;
    localparam int P  = 2;
    localparam int L  = 32;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           init;
    logic [L-1:0]   init_pc;
    logic [P-1:0]   fetch_valid;
    logic [P-1:0]   fetch_ready;
    logic [P*L-1:0] fetch_pc;
    logic [P*IW-1:0] fetch_cntx;
    logic [P-1:0]   dec_next_pc_valid;
    logic [P*L-1:0] dec_next_pc;
    logic [P-1:0]   dec_branch;
    logic [P*L-1:0] dec_pc_f;
    logic [P*IW-1:0] alloc_t_id;
    logic [P*IW-1:0] alloc_f_id;
    logic           jmp_valid;
    logic [IW-1:0]  jmp_cntx;
    logic [L-1:0]   jmp_pc;
    logic           res_valid;
    logic [IW-1:0]  res_keep_id;
    logic [IW-1:0]  res_kill_id;
    logic           flush_valid;
    logic [N-1:0]   flush_mask;
    logic [IW:0]    free_cnt;

    always #5 clk = ~clk;

    cntx_table #(.N_CNTX(N), .PARA(P), .LEN_WORD(L)) dut (
        .clk(clk), .rst(rst), .init(init), .init_pc(init_pc),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_cntx(fetch_cntx),
        .dec_next_pc_valid(dec_next_pc_valid), .dec_next_pc(dec_next_pc),
        .dec_branch(dec_branch), .dec_pc_f(dec_pc_f),
        .alloc_t_id(alloc_t_id), .alloc_f_id(alloc_f_id),
        .jmp_valid(jmp_valid), .jmp_cntx(jmp_cntx), .jmp_pc(jmp_pc),
        .res_valid(res_valid), .res_keep_id(res_keep_id), .res_kill_id(res_kill_id),
        .flush_valid(flush_valid), .flush_mask(flush_mask), .free_cnt(free_cnt)
    );

    typedef struct { int cyc; int slot; logic [L-1:0] pc; int cntx; int t; int f; } fexp_t;
    typedef struct { int cyc; logic [N-1:0] mask; } flexp_t;

    fexp_t  fq[$];
    flexp_t flq[$];
    int     frq[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: a tree of live contexts held as parent/sibling links.
    bit           mv[N];
    bit           mp[N];
    logic [L-1:0] mpc[N];
    int           par[N];
    int           sib[N];
    int           mhot;
    bit           fl_pend;
    logic [N-1:0] fl_mask;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            mv[j] = 0; mp[j] = 0; mpc[j] = '0; par[j] = -1; sib[j] = -1;
        end
        mhot    = 0;
        fl_pend = 0;
        fl_mask = '0;
    endtask

    function automatic bit in_subtree(input int j, input int k);
        int x;
        x = j;
        for (int n = 0; n <= N; n++) begin
            if (x < 0) return 0;
            if (x == k) return 1;
            x = par[x];
        end
        return 0;
    endfunction

    task automatic step();
        int           nf;
        bit           grant[N];
        logic [N-1:0] k;
        bit           ok;
        bit           ev;
        int           t, f;
        cyc++;
        nf = 0;
        for (int j = 0; j < N; j++) if (!mv[j]) nf++;
        frq.push_back(nf);
        if (fl_pend) flq.push_back('{cyc, fl_mask});
        fl_pend = 0;
        if (init) begin
            model_reset();
            mv[0] = 1; mp[0] = 1; mpc[0] = init_pc;
            return;
        end
        for (int j = 0; j < N; j++) grant[j] = !mv[j];
        if (res_valid) begin
            k = '0;
            for (int j = 0; j < N; j++)
                if (mv[j] && in_subtree(j, int'(res_kill_id))) k[j] = 1'b1;
            for (int j = 0; j < N; j++)
                if (k[j]) begin mv[j] = 0; mp[j] = 0; par[j] = -1; sib[j] = -1; end
            if (k[mhot]) mhot = int'(res_keep_id);
            fl_pend = 1;
            fl_mask = k;
        end
        if (jmp_valid && mv[jmp_cntx]) begin
            mpc[jmp_cntx] = jmp_pc;
            mp[jmp_cntx]  = 1;
        end
        ok = 1;
        for (int d = 0; d < P; d++) begin
            t = -1; f = -1;
            for (int j = 0; j < N; j++)
                if (grant[j]) begin
                    if (t < 0) t = j; else if (f < 0) f = j;
                end
            ev = ok && mp[mhot] && (f >= 0);
            if (ev) fq.push_back('{cyc, d, mpc[mhot], mhot, t, f});
            if (ev && fetch_ready[d]) begin
                if (dec_branch[d]) begin
                    grant[t] = 0; grant[f] = 0;
                    mv[t] = 1; mv[f] = 1; mp[t] = 1; mp[f] = 1;
                    mpc[t] = dec_next_pc[d*L +: L];
                    mpc[f] = dec_pc_f[d*L +: L];
                    par[t] = mhot; par[f] = mhot;
                    sib[t] = f; sib[f] = t;
                    mp[mhot] = 0;
                    mhot = t;
                end else begin
                    mp[mhot] = dec_next_pc_valid[d];
                    if (dec_next_pc_valid[d]) mpc[mhot] = dec_next_pc[d*L +: L];
                end
            end else begin
                ok = 0;
            end
        end
    endtask

    task automatic idle_inputs();
        init = 0; init_pc = '0; fetch_ready = '0;
        dec_next_pc_valid = '0; dec_next_pc = '0; dec_branch = '0; dec_pc_f = '0;
        jmp_valid = 0; jmp_cntx = '0; jmp_pc = '0;
        res_valid = 0; res_keep_id = '0; res_kill_id = '0;
    endtask

    task automatic rand_inputs();
        int cand[$];
        int pick;
        idle_inputs();
        fetch_ready = P'($urandom_range(0, 3));
        for (int d = 0; d < P; d++) begin
            dec_branch[d]        = ($urandom_range(0, 99) < 35);
            dec_next_pc_valid[d] = ($urandom_range(0, 9) < 8);
            dec_next_pc[d*L +: L] = $urandom & 32'hffff_fffc;
            dec_pc_f[d*L +: L]    = $urandom & 32'hffff_fffc;
        end
        if ($urandom_range(0, 99) < 30) begin
            for (int j = 0; j < N; j++)
                if (mv[j] && par[j] >= 0 && sib[j] >= 0 && mv[sib[j]] && sib[sib[j]] == j)
                    cand.push_back(j);
            if (cand.size() > 0) begin
                pick        = cand[$urandom_range(0, cand.size() - 1)];
                res_valid   = 1;
                res_kill_id = IW'(pick);
                res_keep_id = IW'(sib[pick]);
            end
        end
        cand.delete();
        if (res_valid && $urandom_range(0, 99) < 30) begin
            jmp_valid = 1;
            jmp_cntx  = res_kill_id;
        end else if ($urandom_range(0, 99) < 40) begin
            for (int j = 0; j < N; j++) if (mv[j] && !mp[j]) cand.push_back(j);
            if (cand.size() > 0) begin
                jmp_valid = 1;
                jmp_cntx  = IW'(cand[$urandom_range(0, cand.size() - 1)]);
            end
        end
        jmp_pc = $urandom & 32'hffff_fffc;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    initial begin
        fexp_t  e;
        flexp_t fe;
        int     fr;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int d = 0; d < P; d++) begin
                    if (fetch_valid[d]) begin
                        checks++;
                        if (fq.size() == 0) begin
                            errors++;
                            $display("FAIL fetch_unexpected: slot %0d pc %0h at cycle %0d, none expected",
                                     d, fetch_pc[d*L +: L], cyc);
                        end else begin
                            e = fq.pop_front();
                            if (e.cyc != cyc || e.slot != d || fetch_pc[d*L +: L] !== e.pc ||
                                int'(fetch_cntx[d*IW +: IW]) != e.cntx ||
                                int'(alloc_t_id[d*IW +: IW]) != e.t ||
                                int'(alloc_f_id[d*IW +: IW]) != e.f) begin
                                errors++;
                                $display("FAIL fetch: got cyc=%0d slot=%0d pc=%0h cntx=%0d t=%0d f=%0d expected cyc=%0d slot=%0d pc=%0h cntx=%0d t=%0d f=%0d",
                                         cyc, d, fetch_pc[d*L +: L], fetch_cntx[d*IW +: IW],
                                         alloc_t_id[d*IW +: IW], alloc_f_id[d*IW +: IW],
                                         e.cyc, e.slot, e.pc, e.cntx, e.t, e.f);
                            end
                        end
                    end
                end
                if (flush_valid) begin
                    checks++;
                    if (flq.size() == 0) begin
                        errors++;
                        $display("FAIL flush_unexpected: mask %0h at cycle %0d, none expected",
                                 flush_mask, cyc);
                    end else begin
                        fe = flq.pop_front();
                        if (fe.cyc != cyc || flush_mask !== fe.mask) begin
                            errors++;
                            $display("FAIL flush: got cyc=%0d mask=%0h expected cyc=%0d mask=%0h",
                                     cyc, flush_mask, fe.cyc, fe.mask);
                        end
                    end
                end
                if (frq.size() > 0) begin
                    fr = frq.pop_front();
                    chk("free_cnt", 64'(free_cnt), 64'(fr));
                end
            end
        end
    end

    initial begin
        idle_inputs();
        model_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("reset_fetch_valid", 64'(fetch_valid), 64'(0));
        chk("reset_fetch_pc", 64'(fetch_pc), 64'(0));
        chk("reset_alloc", 64'({alloc_t_id, alloc_f_id}), 64'(0));
        chk("reset_flush", 64'({flush_valid, flush_mask}), 64'(0));
        chk("reset_free_cnt", 64'(free_cnt), 64'(N));

        // no fetch before init, even with ready asserted
        repeat (2) begin
            @(negedge clk); idle_inputs(); fetch_ready = '1; step();
        end

        @(negedge clk); idle_inputs(); init = 1; init_pc = 32'h100; step();
        @(negedge clk); idle_inputs(); fetch_ready = 2'b11; dec_next_pc_valid = 2'b11;
        dec_next_pc = {32'h108, 32'h104}; step();
        #2;
        chk("seq_slot0_pc", 64'(fetch_pc[0 +: L]), 64'h100);
        chk("seq_slot1_pc", 64'(fetch_pc[L +: L]), 64'h104);
        @(negedge clk); step();
        #2;
        chk("seq_next_slot0_pc", 64'(fetch_pc[0 +: L]), 64'h108);

        @(negedge clk); idle_inputs(); init = 1; init_pc = 32'h100; step();
        @(negedge clk); idle_inputs(); fetch_ready = 2'b11; dec_branch = 2'b01;
        dec_next_pc_valid = 2'b11; dec_next_pc = {32'h204, 32'h200};
        dec_pc_f = {32'h0, 32'h104}; step();
        #2;
        chk("br_alloc_t", 64'(alloc_t_id[0 +: IW]), 64'(1));
        chk("br_alloc_f", 64'(alloc_f_id[0 +: IW]), 64'(2));
        chk("br_slot1_pc", 64'(fetch_pc[L +: L]), 64'h200);
        chk("br_slot1_cntx", 64'(fetch_cntx[IW +: IW]), 64'(1));
        @(negedge clk); idle_inputs(); res_valid = 1; res_keep_id = 3'd2; res_kill_id = 3'd1; step();
        #2;
        chk("br_free_cnt", 64'(free_cnt), 64'(5));
        @(negedge clk); idle_inputs(); step();
        #2;
        chk("res_flush_valid", 64'(flush_valid), 64'(1));
        chk("res_flush_mask", 64'(flush_mask), 64'h02);
        chk("res_hot_pc", 64'(fetch_pc[0 +: L]), 64'h104);
        chk("res_hot_cntx", 64'(fetch_cntx[0 +: IW]), 64'(2));

        repeat (1500) begin
            @(negedge clk); rand_inputs(); step();
        end

        // asynchronous reset in the middle of a cycle
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("midrst_fetch_valid", 64'(fetch_valid), 64'(0));
        chk("midrst_flush_valid", 64'(flush_valid), 64'(0));
        chk("midrst_free_cnt", 64'(free_cnt), 64'(N));
        model_reset();
        @(negedge clk); rst = 0; idle_inputs(); init = 1; init_pc = 32'h4000; step();

        repeat (1500) begin
            @(negedge clk); rand_inputs(); step();
        end

        repeat (3) begin
            @(negedge clk); idle_inputs(); step();
        end
        @(negedge clk); #4;
        chk("fetch_queue_drained", 64'(fq.size()), 64'(0));
        chk("flush_queue_drained", 64'(flq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
